// File: rtl/midi_byte_parser_if.sv
// Byte-stream and decoded-message bundle between the UART receiver, midi_byte_parser and the
// trigger stage. The master side feeds bytes in; the slave side is the parser.
interface midi_byte_parser_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [3:0] sel_midi_ch;
  logic [3:0] midi_ch;
  logic [7:0] status_byte;
  logic       byteready;
  logic [7:0] midibyte_nr;
  logic [7:0] midi_in_data;
  logic       is_cur_midi_ch;
  logic       is_st_sysex;
  logic       syx_end;
  logic       rt_valid;
  logic [7:0] rt_byte;
  logic       as_timeout;

  modport master (
    output rx_byte, rx_valid, sel_midi_ch,
    input  midi_ch, status_byte, byteready, midibyte_nr, midi_in_data, is_cur_midi_ch,
           is_st_sysex, syx_end, rt_valid, rt_byte, as_timeout
  );

  modport slave (
    input  rx_byte, rx_valid, sel_midi_ch,
    output midi_ch, status_byte, byteready, midibyte_nr, midi_in_data, is_cur_midi_ch,
           is_st_sysex, syx_end, rt_valid, rt_byte, as_timeout
  );
endinterface

// File: rtl/midi_byte_parser.sv
// MIDI byte parser: running status, data-byte indexing, sysex framing and real-time bypass.
// Optional active-sense timeout enabled by defining MIDI_ACTIVE_SENSE_EN.
module midi_byte_parser #(
  parameter int unsigned SYX_MAX       = 255,
  parameter int unsigned CLK_HZ        = 50000000,
  parameter int unsigned AS_TIMEOUT_MS = 300
) (
  input logic                 data_clk,
  input logic                 reset_reg_N,
  midi_byte_parser_if.slave   bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StChan   = 2'd1;
  localparam logic [1:0] StSyscom = 2'd2;
  localparam logic [1:0] StSysex  = 2'd3;
  localparam logic [7:0] SyxMax   = SYX_MAX[7:0];

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] len_q, len_d;
  logic [7:0] status_q, status_d;
  logic [3:0] ch_q, ch_d;
  logic       cur_ch_q, cur_ch_d;
  logic       sysex_q, sysex_d;
  logic       byteready_q, byteready_d;
  logic [7:0] nr_q, nr_d;
  logic [7:0] data_q, data_d;
  logic       syx_end_q, syx_end_d;
  logic       rt_valid_q, rt_valid_d;
  logic [7:0] rt_byte_q, rt_byte_d;
  logic       as_timeout_q, as_timeout_d;
  logic [7:0] nr_next;

`ifdef MIDI_ACTIVE_SENSE_EN
  localparam int unsigned AsCycles = CLK_HZ / 1000 * AS_TIMEOUT_MS;
  logic [31:0] tmr_q, tmr_d;
  logic        armed_q, armed_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    status_d     = status_q;
    ch_d         = ch_q;
    cur_ch_d     = cur_ch_q;
    sysex_d      = sysex_q;
    nr_d         = nr_q;
    data_d       = data_q;
    rt_byte_d    = rt_byte_q;
    byteready_d  = 1'b0;
    syx_end_d    = 1'b0;
    rt_valid_d   = 1'b0;
    as_timeout_d = 1'b0;
    nr_next      = cnt_q + 8'd1;

    if (bus.rx_valid) begin
      if (bus.rx_byte >= 8'hF8) begin
        rt_valid_d = 1'b1;
        rt_byte_d  = bus.rx_byte;
      end else if (bus.rx_byte[7] && bus.rx_byte < 8'hF0) begin
        status_d = bus.rx_byte;
        ch_d     = bus.rx_byte[3:0];
        cur_ch_d = (bus.rx_byte[3:0] == bus.sel_midi_ch);
        state_d  = StChan;
        sysex_d  = 1'b0;
        cnt_d    = 8'd0;
        // Program change (Cx) and channel pressure (Dx) carry a single data byte.
        len_d    = (bus.rx_byte[7:5] == 3'b110) ? 2'd1 : 2'd2;
      end else if (bus.rx_byte[7]) begin
        case (bus.rx_byte)
          8'hF0: begin
            status_d = 8'hF0;
            state_d  = StSysex;
            sysex_d  = 1'b1;
            cur_ch_d = 1'b0;
            cnt_d    = 8'd0;
          end
          8'hF7: begin
            if (state_q == StSysex) begin
              syx_end_d = 1'b1;
              sysex_d   = 1'b0;
              status_d  = 8'h00;
              state_d   = StIdle;
              cnt_d     = 8'd0;
            end
          end
          8'hF1, 8'hF2, 8'hF3, 8'hF6: begin
            status_d = bus.rx_byte;
            state_d  = StSyscom;
            cur_ch_d = 1'b0;
            sysex_d  = 1'b0;
            cnt_d    = 8'd0;
            len_d    = (bus.rx_byte == 8'hF2) ? 2'd2 : (bus.rx_byte == 8'hF6) ? 2'd0 : 2'd1;
          end
          default: begin
            status_d = 8'h00;
            state_d  = StIdle;
            cur_ch_d = 1'b0;
            sysex_d  = 1'b0;
            cnt_d    = 8'd0;
          end
        endcase
      end else begin
        case (state_q)
          StChan, StSyscom: begin
            if (len_q == 2'd0) begin
              state_d = StIdle;
            end else begin
              byteready_d = 1'b1;
              nr_d        = nr_next;
              data_d      = bus.rx_byte;
              // Message complete: rewind for running status; system common has none.
              if (nr_next == {6'd0, len_q}) begin
                cnt_d = 8'd0;
                if (state_q == StSyscom) state_d = StIdle;
              end else begin
                cnt_d = nr_next;
              end
            end
          end
          StSysex: begin
            byteready_d = 1'b1;
            data_d      = bus.rx_byte;
            cnt_d       = (cnt_q == SyxMax) ? cnt_q : nr_next;
            nr_d        = (cnt_q == SyxMax) ? cnt_q : nr_next;
          end
          default: ;
        endcase
      end
    end

`ifdef MIDI_ACTIVE_SENSE_EN
    armed_d = armed_q;
    tmr_d   = tmr_q;
    if (bus.rx_valid) begin
      if (armed_q || bus.rx_byte == 8'hFE) begin
        armed_d = 1'b1;
        tmr_d   = AsCycles - 32'd1;
      end
    end else if (armed_q) begin
      if (tmr_q == 32'd0) begin
        as_timeout_d = 1'b1;
        armed_d      = 1'b0;
        state_d      = StIdle;
        status_d     = 8'h00;
        cur_ch_d     = 1'b0;
        sysex_d      = 1'b0;
        cnt_d        = 8'd0;
      end else begin
        tmr_d = tmr_q - 32'd1;
      end
    end
`endif
  end

  always_ff @(posedge data_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q      <= StIdle;
      cnt_q        <= 8'd0;
      len_q        <= 2'd0;
      status_q     <= 8'd0;
      ch_q         <= 4'd0;
      cur_ch_q     <= 1'b0;
      sysex_q      <= 1'b0;
      byteready_q  <= 1'b0;
      nr_q         <= 8'd0;
      data_q       <= 8'd0;
      syx_end_q    <= 1'b0;
      rt_valid_q   <= 1'b0;
      rt_byte_q    <= 8'd0;
      as_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      status_q     <= status_d;
      ch_q         <= ch_d;
      cur_ch_q     <= cur_ch_d;
      sysex_q      <= sysex_d;
      byteready_q  <= byteready_d;
      nr_q         <= nr_d;
      data_q       <= data_d;
      syx_end_q    <= syx_end_d;
      rt_valid_q   <= rt_valid_d;
      rt_byte_q    <= rt_byte_d;
      as_timeout_q <= as_timeout_d;
    end
  end

`ifdef MIDI_ACTIVE_SENSE_EN
  always_ff @(posedge data_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      tmr_q   <= 32'd0;
      armed_q <= 1'b0;
    end else begin
      tmr_q   <= tmr_d;
      armed_q <= armed_d;
    end
  end
  assign bus.as_timeout = as_timeout_q;
`else
  assign bus.as_timeout = 1'b0;
`endif

  assign bus.midi_ch        = ch_q;
  assign bus.status_byte    = status_q;
  assign bus.byteready      = byteready_q;
  assign bus.midibyte_nr    = nr_q;
  assign bus.midi_in_data   = data_q;
  assign bus.is_cur_midi_ch = cur_ch_q;
  assign bus.is_st_sysex    = sysex_q;
  assign bus.syx_end        = syx_end_q;
  assign bus.rt_valid       = rt_valid_q;
  assign bus.rt_byte        = rt_byte_q;

endmodule

// File: tb/tb_midi_byte_parser.sv
// Bench for midi_byte_parser: directed message sequences plus a random byte stream, all
// compared against a message-level model of the MIDI protocol rules.
module tb_midi_byte_parser;
  logic data_clk = 1'b0;
  logic reset_reg_N = 1'b0;
  int   total = 0;
  int   bad = 0;

  midi_byte_parser_if bus ();

  midi_byte_parser #(
    .SYX_MAX       (255),
    .CLK_HZ        (1000000),
    .AS_TIMEOUT_MS (1)
  ) dut (
    .data_clk    (data_clk),
    .reset_reg_N (reset_reg_N),
    .bus         (bus)
  );

  always #5 data_clk = ~data_clk;

  // Protocol-level model state.
  logic [7:0] m_status, m_nr, m_data, m_rt;
  logic [3:0] m_ch;
  logic       m_cur, m_sysex, m_live;
  logic       exp_br, exp_syx, exp_rt, exp_as;
  int         m_idx;

  function automatic int msg_len(input logic [7:0] s);
    if (s >= 8'hC0 && s < 8'hE0) return 1;
    if (s < 8'hF0) return 2;
    if (s == 8'hF1 || s == 8'hF3) return 1;
    if (s == 8'hF2) return 2;
    return 0;
  endfunction

  function automatic void model_reset();
    m_status = 0; m_nr = 0; m_data = 0; m_rt = 0; m_ch = 0;
    m_cur = 0; m_sysex = 0; m_live = 0; m_idx = 0;
    exp_br = 0; exp_syx = 0; exp_rt = 0; exp_as = 0;
  endfunction

  function automatic void model_idle();
    exp_br = 0; exp_syx = 0; exp_rt = 0; exp_as = 0;
  endfunction

  function automatic void model_step(input logic [7:0] b, input logic [3:0] sel);
    model_idle();
    if (b >= 8'hF8) begin
      exp_rt = 1; m_rt = b;
    end else if (b >= 8'hF0) begin
      if (b == 8'hF0) begin
        m_status = b; m_sysex = 1; m_cur = 0; m_live = 1; m_idx = 0;
      end else if (b == 8'hF7) begin
        if (m_sysex) begin
          exp_syx = 1; m_sysex = 0; m_status = 0; m_live = 0; m_idx = 0;
        end
      end else if (b == 8'hF4 || b == 8'hF5) begin
        m_status = 0; m_cur = 0; m_sysex = 0; m_live = 0; m_idx = 0;
      end else begin
        m_status = b; m_cur = 0; m_sysex = 0; m_idx = 0; m_live = (msg_len(b) != 0);
      end
    end else if (b >= 8'h80) begin
      m_status = b; m_ch = b[3:0]; m_cur = (b[3:0] == sel);
      m_sysex = 0; m_live = 1; m_idx = 0;
    end else if (m_live) begin
      exp_br = 1; m_data = b;
      if (m_sysex) begin
        m_idx = (m_idx < 255) ? m_idx + 1 : 255;
        m_nr  = 8'(m_idx);
      end else begin
        m_nr  = 8'(m_idx + 1);
        m_idx = (m_idx + 1) % msg_len(m_status);
        if (m_status >= 8'hF0 && m_idx == 0) m_live = 0;
      end
    end
  endfunction

  function automatic logic [41:0] exp_vec();
    return {m_ch, m_status, exp_br, m_nr, m_data, m_cur, m_sysex, exp_syx, exp_rt, m_rt, exp_as};
  endfunction

  function automatic logic [41:0] obs_vec();
    return {bus.midi_ch, bus.status_byte, bus.byteready, bus.midibyte_nr, bus.midi_in_data,
            bus.is_cur_midi_ch, bus.is_st_sysex, bus.syx_end, bus.rt_valid, bus.rt_byte,
            bus.as_timeout};
  endfunction

  // Called at a falling edge; returns at the next falling edge with outputs updated.
  task automatic drive(input logic [7:0] b);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    @(negedge data_clk);
    bus.rx_valid = 1'b0;
    model_step(b, bus.sel_midi_ch);
  endtask

  task automatic do_reset();
    reset_reg_N = 1'b0;
    @(negedge data_clk);
    reset_reg_N = 1'b1;
    model_reset();
    @(negedge data_clk);
  endtask

  task automatic test_reset();
    reset_reg_N = 1'b0;
    #1;
    model_reset();
    total++;
    if (obs_vec() !== exp_vec())
      $display("FAIL reset got=%h want=%h", obs_vec(), exp_vec());
    if (obs_vec() !== exp_vec()) bad++;
    @(negedge data_clk);
    reset_reg_N = 1'b1;
    @(negedge data_clk);
  endtask

  task automatic test_note_on();
    logic [7:0] seq [3];
    seq = '{8'h90, 8'h3C, 8'h64};
    bus.sel_midi_ch = 4'd0;
    foreach (seq[i]) begin
      drive(seq[i]);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL note_on byte=%h got=%h want=%h", seq[i], obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_running_status();
    logic [7:0] seq [5];
    seq = '{8'h93, 8'h40, 8'h7F, 8'h41, 8'h00};
    bus.sel_midi_ch = 4'd3;
    foreach (seq[i]) begin
      drive(seq[i]);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL running_status byte=%h got=%h want=%h", seq[i], obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_prog_change();
    logic [7:0] seq [3];
    seq = '{8'hC5, 8'h07, 8'h08};
    bus.sel_midi_ch = 4'd2;
    foreach (seq[i]) begin
      drive(seq[i]);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL prog_change byte=%h got=%h want=%h", seq[i], obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_sysex_rt();
    logic [7:0] seq [5];
    seq = '{8'hF0, 8'h43, 8'hF8, 8'h10, 8'hF7};
    foreach (seq[i]) begin
      drive(seq[i]);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL sysex_rt byte=%h got=%h want=%h", seq[i], obs_vec(), exp_vec());
      end
    end
    @(negedge data_clk);
    model_idle();
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL sysex_rt_idle got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_sysex_saturate();
    logic [7:0] b;
    drive(8'hF0);
    for (int i = 0; i < 300; i++) begin
      b = 8'($urandom_range(0, 127));
      drive(b);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL sysex_sat idx=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    reset_reg_N = 1'b0;
    #1;
    model_reset();
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL mid_frame_reset got=%h want=%h", obs_vec(), exp_vec());
    end
    @(negedge data_clk);
    reset_reg_N = 1'b1;
    @(negedge data_clk);
    drive(8'h11);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL post_reset_data got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic [7:0] sc [6];
    int r;
    sc = '{8'hF1, 8'hF2, 8'hF3, 8'hF6, 8'hF4, 8'hF5};
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      b = 8'($urandom_range(0, 127));
      else if (r < 65) b = 8'($urandom_range(128, 239));
      else if (r < 72) b = 8'hF0;
      else if (r < 80) b = 8'hF7;
      else if (r < 86) b = sc[$urandom_range(0, 5)];
      else             b = 8'($urandom_range(248, 255));
      if ($urandom_range(0, 9) == 0) bus.sel_midi_ch = 4'($urandom_range(0, 15));
      drive(b);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL random i=%0d byte=%h got=%h want=%h", i, b, obs_vec(), exp_vec());
      end
      if ($urandom_range(0, 2) == 0) begin
        @(negedge data_clk);
        model_idle();
        total++;
        if (obs_vec() !== exp_vec()) begin
          bad++;
          $display("FAIL random_gap i=%0d got=%h want=%h", i, obs_vec(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_active_sense();
    int k;
    logic seen;
    do_reset();
    bus.sel_midi_ch = 4'd3;
    drive(8'h93);
    drive(8'hFE);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL as_fe got=%h want=%h", obs_vec(), exp_vec());
    end
`ifdef MIDI_ACTIVE_SENSE_EN
    k = 0;
    seen = 1'b0;
    while (k < 2000 && !seen) begin
      @(negedge data_clk);
      k++;
      seen = bus.as_timeout;
    end
    total++;
    if (k != 1000 || !seen) begin
      bad++;
      $display("FAIL as_delay got=%0d want=1000 (seen=%0b)", k, seen);
    end
    model_idle();
    exp_as = 1; m_status = 0; m_cur = 0; m_sysex = 0; m_live = 0; m_idx = 0;
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL as_expiry got=%h want=%h", obs_vec(), exp_vec());
    end
    @(negedge data_clk);
    model_idle();
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL as_single got=%h want=%h", obs_vec(), exp_vec());
    end
`else
    seen = 1'b0;
    for (k = 0; k < 1100; k++) begin
      @(negedge data_clk);
      if (bus.as_timeout !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL as_disabled got=%0b want=0", seen);
    end
`endif
  endtask

  initial begin
    bus.rx_byte     = 8'h00;
    bus.rx_valid    = 1'b0;
    bus.sel_midi_ch = 4'd0;
    model_reset();
    @(negedge data_clk);
    test_reset();
    test_note_on();
    test_running_status();
    test_prog_change();
    test_sysex_rt();
    test_sysex_saturate();
    test_random();
    test_active_sense();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
